// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master: frame geometry, FSM states
// and the frame-building helper used when a transaction is accepted.
package spi_master_pkg;

  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int FRAME_BITS  = 16;
  localparam int CLK_DIV_DEF = 4;
  localparam int BIT_CNT_W   = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Reads put zeros in the data phase; the peripheral drives miso instead.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ADDR_W-1:0] addr,
    input logic              rw,
    input logic [DATA_W-1:0] wdata
  );
    return {addr, rw, (rw ? {DATA_W{1'b0}} : wdata)};
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response signals and the SPI pins of the master, grouped
// so the master and its surroundings connect through one port.
interface spi_master_if;
  import spi_master_pkg::*;

  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, rw, addr, wdata, miso,
    output busy, done, rdata, sclk, cs, mosi
  );

  modport slave (
    output start, rw, addr, wdata, miso,
    input  busy, done, rdata, sclk, cs, mosi
  );

endinterface

// File: rtl/spi_master_sclk_gen.sv
// Half-period counter and SPI clock generator. tick marks the last cycle of
// every half-period; rise/fall flag the edges on which sclk will toggle.
module sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic shift_en,
  output logic sclk,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == CNT_LAST);
  assign rise = tick && shift_en && !sclk;
  assign fall = tick && shift_en && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && shift_en) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master issuing 16-bit address/rw/data frames; the FSM sequences
// setup, shifting, hold and inter-frame gap on half-period ticks from sclk_gen.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  state_t                state_q, state_d;
  logic                  done_q, done_d;
  logic                  sclk, tick, rise, fall;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [DATA_W-1:0]     rx_sr;
  logic [DATA_W-1:0]     rdata_q;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  rw_q;
  logic                  accept;
  logic                  last_bit;

  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state_q != ST_IDLE),
    .shift_en (state_q == ST_SHIFT),
    .sclk     (sclk),
    .tick     (tick),
    .rise     (rise),
    .fall     (fall)
  );

  assign accept   = (state_q == ST_IDLE) && bus.start;
  assign last_bit = (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (fall && last_bit) state_d = ST_HOLD;
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
        end
      end
      ST_GAP:   if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Frame is latched on acceptance; later input changes cannot disturb it.
  // The shifter drains to zero, which keeps mosi low outside the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      rdata_q <= '0;
      bit_cnt <= '0;
      rw_q    <= 1'b0;
    end else begin
      if (accept) begin
        tx_sr   <= build_frame(bus.addr, bus.rw, bus.wdata);
        rw_q    <= bus.rw;
        bit_cnt <= '0;
      end else if (fall) begin
        tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      // Only the data half of the frame (rising edges 9..16) is captured.
      if (rise && bit_cnt[BIT_CNT_W-1]) rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
      if ((state_q == ST_HOLD) && tick && rw_q) rdata_q <= rx_sr;
    end
  end

  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.cs    = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.sclk  = sclk;
  assign bus.mosi  = tx_sr[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master at CLK_DIV=2 with a mode-0
// peripheral model and a frame-level reference model.
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int D      = 2;
  localparam int LAT    = 34 * D + 1;
  localparam int CS_LOW = 34 * D;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_if bus();

  spi_master #(.CLK_DIV(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rdata = 8'h00;

  // Frame-level monitor: cs low/high run lengths, done cycles, mosi while idle.
  int low_run = 0, last_low = 0, hi_run = 0, last_gap = 0;
  int done_total = 0, cs_falls = 0, cs_mosi_viol = 0;
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_total++;
    if (bus.cs === 1'b1 && bus.mosi !== 1'b0) cs_mosi_viol++;
    if (bus.cs === 1'b0) begin
      if (hi_run > 0) begin
        last_gap = hi_run;
        cs_falls++;
      end
      hi_run = 0;
      low_run++;
    end else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
      hi_run++;
    end
  end

  // Mode-0 peripheral: samples mosi on rising sclk, shifts miso after falling
  // sclk (first bit presented when cs drops).
  logic [15:0] resp_frame = 16'h0000;
  logic [15:0] mosi_cap   = 16'h0000;
  int rise_cnt = 0;
  always @(negedge bus.cs or posedge bus.cs or posedge bus.sclk or negedge bus.sclk) begin
    if (bus.cs !== 1'b0) begin
      rise_cnt = 0;
      bus.miso = 1'b0;
    end else if (bus.sclk === 1'b1) begin
      mosi_cap = {mosi_cap[14:0], bus.mosi};
      rise_cnt++;
    end else if (rise_cnt < 16) begin
      bus.miso = resp_frame[15 - rise_cnt];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issues one frame from a negedge; returns start-to-done cycles and rdata at done.
  task automatic do_frame(input logic [6:0] a, input logic r, input logic [7:0] wd,
                          input logic [7:0] resp, output int lat, output logic [7:0] rd);
    logic [7:0] junk;
    junk       = 8'($urandom);
    resp_frame = {junk, resp};
    bus.addr   = a;
    bus.rw     = r;
    bus.wdata  = wd;
    bus.start  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      if (lat == 1) begin
        bus.addr  = 7'($urandom);
        bus.wdata = 8'($urandom);
        bus.rw    = 1'($urandom);
      end
    end while (bus.done !== 1'b1 && lat < 500);
    rd = bus.rdata;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", bus.cs); end
    checks++; if (bus.sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", bus.sclk); end
    checks++; if (bus.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", bus.mosi); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
    exp_rdata = 8'h00;
    idle_wait(2);
    rst_n = 1'b1;
    idle_wait(2);
  endtask

  task automatic test_write;
    int lat, d0;
    logic [7:0] rd;
    d0 = done_total;
    do_frame(7'h00, 1'b0, 8'hFF, 8'h00, lat, rd);
    checks++; if (lat != LAT) begin errors++; $display("FAIL write_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL write_rdata: got %h expected %h", rd, exp_rdata); end
    idle_wait(D + 3);
    checks++; if (mosi_cap !== 16'h00FF) begin errors++; $display("FAIL write_mosi: got %h expected 00ff", mosi_cap); end
    checks++; if (last_low != CS_LOW) begin errors++; $display("FAIL write_cs_low: got %0d expected %0d", last_low, CS_LOW); end
    checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL write_done_cycles: got %0d expected 1", done_total - d0); end
  endtask

  task automatic test_read;
    int lat;
    logic [7:0] rd;
    do_frame(7'h55, 1'b1, 8'h3E, 8'hA5, lat, rd);
    exp_rdata = 8'hA5;
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h expected a5", rd); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL read_latency: got %0d expected %0d", lat, LAT); end
    idle_wait(D + 3);
    checks++; if (mosi_cap !== 16'hAB00) begin errors++; $display("FAIL read_mosi: got %h expected ab00", mosi_cap); end
    checks++; if (last_low != CS_LOW) begin errors++; $display("FAIL read_cs_low: got %0d expected %0d", last_low, CS_LOW); end
  endtask

  task automatic test_ignore_start;
    int d0, f0;
    logic [6:0] a;
    logic [7:0] resp, junk;
    a = 7'($urandom); resp = 8'($urandom); junk = 8'($urandom);
    resp_frame = {junk, resp};
    d0 = done_total; f0 = cs_falls;
    bus.addr = a; bus.rw = 1'b1; bus.wdata = 8'($urandom);
    bus.start = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      bus.start = (n == 5 || n == 30);
    end
    bus.start = 1'b0;
    exp_rdata = resp;
    checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_total - d0); end
    checks++; if (cs_falls - f0 != 1) begin errors++; $display("FAIL ignore_frames: got %0d expected 1", cs_falls - f0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %b expected 0", bus.busy); end
    checks++; if (mosi_cap !== {a, 1'b1, 8'h00}) begin errors++; $display("FAIL ignore_mosi: got %h expected %h", mosi_cap, {a, 1'b1, 8'h00}); end
    checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL ignore_rdata: got %h expected %h", bus.rdata, exp_rdata); end
  endtask

  task automatic test_reset_mid;
    int n, lat, d0;
    logic [7:0] rd;
    resp_frame = {8'h5A, 8'hC3};
    bus.addr = 7'($urandom); bus.rw = 1'b1; bus.wdata = 8'($urandom);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (rise_cnt < 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++; if (rise_cnt != 5) begin errors++; $display("FAIL midrst_reach_edge5: got %0d expected 5", rise_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL midrst_cs: got %b expected 1", bus.cs); end
    checks++; if (bus.sclk !== 1'b0) begin errors++; $display("FAIL midrst_sclk: got %b expected 0", bus.sclk); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.mosi !== 1'b0) begin errors++; $display("FAIL midrst_mosi: got %b expected 0", bus.mosi); end
    d0 = done_total;
    exp_rdata = 8'h00;
    idle_wait(3);
    rst_n = 1'b1;
    idle_wait(40 * D);
    checks++; if (done_total != d0) begin errors++; $display("FAIL midrst_no_done: got %0d extra done cycles expected 0", done_total - d0); end
    checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL midrst_rdata_cleared: got %h expected %h", bus.rdata, exp_rdata); end
    do_frame(7'h01, 1'b1, 8'($urandom), 8'h3C, lat, rd);
    exp_rdata = 8'h3C;
    checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL midrst_read_rdata: got %h expected 3c", rd); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL midrst_read_latency: got %0d expected %0d", lat, LAT); end
    idle_wait(D + 3);
    checks++; if (mosi_cap !== 16'h0300) begin errors++; $display("FAIL midrst_read_mosi: got %h expected 0300", mosi_cap); end
  endtask

  task automatic test_back_to_back;
    int n, d0, f0, gap;
    logic [6:0] a;
    logic r;
    logic [7:0] wd, resp, junk;
    logic [15:0] exp_frame, cap1;
    a = 7'($urandom); r = 1'($urandom); wd = 8'($urandom); resp = 8'($urandom); junk = 8'($urandom);
    resp_frame = {junk, resp};
    exp_frame = {a, r, (r ? 8'h00 : wd)};
    d0 = done_total; f0 = cs_falls;
    bus.addr = a; bus.rw = r; bus.wdata = wd; bus.start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.done !== 1'b1 && n < 500);
    cap1 = mosi_cap;
    checks++; if (n != LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", n, LAT); end
    n = 0;
    while (bus.cs !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    bus.start = 1'b0;
    @(negedge clk);
    gap = last_gap;
    n = 0;
    while (bus.done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (r) exp_rdata = resp;
    checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL b2b_rdata: got %h expected %h", bus.rdata, exp_rdata); end
    idle_wait(4 * D + 10);
    checks++; if (gap < D + 1) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected at least %0d", gap, D + 1); end
    checks++; if (done_total - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_total - d0); end
    checks++; if (cs_falls - f0 != 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", cs_falls - f0); end
    checks++; if (cap1 !== exp_frame) begin errors++; $display("FAIL b2b_mosi_1: got %h expected %h", cap1, exp_frame); end
    checks++; if (mosi_cap !== exp_frame) begin errors++; $display("FAIL b2b_mosi_2: got %h expected %h", mosi_cap, exp_frame); end
    checks++; if (last_low != CS_LOW) begin errors++; $display("FAIL b2b_cs_low: got %0d expected %0d", last_low, CS_LOW); end
  endtask

  task automatic test_random;
    int lat, d0;
    logic [6:0] a;
    logic r;
    logic [7:0] wd, resp, rd;
    logic [15:0] exp_frame;
    for (int i = 0; i < 8; i++) begin
      a = 7'($urandom); r = 1'($urandom); wd = 8'($urandom); resp = 8'($urandom);
      exp_frame = {a, r, (r ? 8'h00 : wd)};
      if (r) exp_rdata = resp;
      d0 = done_total;
      do_frame(a, r, wd, resp, lat, rd);
      checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL rand%0d_rdata: got %h expected %h", i, rd, exp_rdata); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, LAT); end
      idle_wait(D + 3);
      checks++; if (mosi_cap !== exp_frame) begin errors++; $display("FAIL rand%0d_mosi: got %h expected %h", i, mosi_cap, exp_frame); end
      checks++; if (last_low != CS_LOW) begin errors++; $display("FAIL rand%0d_cs_low: got %0d expected %0d", i, last_low, CS_LOW); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL rand%0d_done_cycles: got %0d expected 1", i, done_total - d0); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++; if (cs_mosi_viol != 0) begin errors++; $display("FAIL mosi_while_cs_high: got %0d cycles expected 0", cs_mosi_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per SCLK half-period; legal values 2..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  transaction request, sampled only in IDLE.
REQ-005 rw  input  1  0 = write, 1 = read.
REQ-006 addr  input  7  peripheral address.
REQ-007 wdata  input  8  write data.
REQ-008 busy  output  1  high while a transaction is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  8  data captured on the last read.
REQ-011 sclk  output  1  SPI serial clock, idle low.
REQ-012 cs  output  1  chip select, active-low, idle high.
REQ-013 mosi  output  1  serial data to the peripheral.
REQ-014 miso  input  1  serial data from the peripheral.

Function
REQ-015 The frame SHALL be 16 bits, MSB first: addr[6:0], then rw, then 8 data bits (wdata for writes, 0 on mosi for reads).
REQ-016 SPI mode 0: mosi changes only on sclk falling edges, or at cs assertion for bit 0; miso is sampled on sclk rising edges.
REQ-017 FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-018 IDLE with start=1 SHALL latch rw/addr/wdata, drive cs=0, mosi=addr[6] and busy=1 on the next edge, and enter SETUP.
REQ-019 SETUP lasts CLK_DIV cycles with sclk low, then enters SHIFT.
REQ-020 SHIFT toggles sclk every CLK_DIV cycles, producing exactly 16 rising and 16 falling edges, and uses a bit counter 0..15.
REQ-021 On read frames, miso is shifted into an internal register on rising edges 9..16; miso on edges 1..8 is ignored.
REQ-022 After the 16th falling edge, HOLD lasts CLK_DIV cycles with sclk=0 and cs=0.
REQ-023 At the end of HOLD: cs=1, done=1 for one cycle, rdata updated on read frames only (unchanged on writes); then enter GAP.
REQ-024 GAP lasts CLK_DIV cycles with busy=1, then returns to IDLE with busy=0.
REQ-025 cs low-time SHALL be exactly 34*CLK_DIV cycles; start-to-done latency SHALL be 34*CLK_DIV+1 cycles.
REQ-026 start outside IDLE SHALL be ignored; input changes after acceptance have no effect on the frame.
REQ-027 start held high SHALL yield back-to-back frames with cs high for at least CLK_DIV+1 cycles between them.
REQ-028 mosi SHALL be 0 whenever cs=1.
REQ-029 The half-period counter SHALL be $clog2(CLK_DIV) bits wide (minimum 1) and SHALL wrap to 0 at CLK_DIV-1.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=IDLE, sclk=0, cs=1, mosi=0, busy=0, done=0, rdata=0, all counters 0.
REQ-031 Reset mid-frame SHALL abort the frame without a done pulse; the first start after release runs a complete frame.

Structure
REQ-032 A shared package SHALL hold the state enumeration, ADDR_W=7, DATA_W=8, FRAME_BITS=16 and the CLK_DIV default.
REQ-033 One sub-module, sclk_gen, SHALL own the half-period counter, sclk, and the one-cycle rise/fall strobes; the FSM and shift logic stay in spi_master.

Verification (CLK_DIV=2, bench miso model mirrors a mode-0 peripheral)
REQ-034 Reset: rst_n=0 mid-idle -> cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=8'h00 without a clock edge.
REQ-035 Write addr=7'h00, wdata=8'hFF -> mosi at the 16 rising edges = 0000000_0_11111111; cs low 68 cycles; done 1 cycle at cycle 69; rdata unchanged.
REQ-036 Read addr=7'h55, peripheral returns 8'hA5 -> mosi bits = 1010101_1_00000000; rdata=8'hA5 when done=1.
REQ-037 start pulsed at cycles 5 and 30 after a start at cycle 0 -> exactly one frame, one done pulse.
REQ-038 rst_n asserted after the 5th rising sclk edge -> immediate cs=1, sclk=0, no done; after release, a read of 7'h01 returning 8'h3C completes with rdata=8'h3C.
REQ-039 start held high for two frames -> two complete frames, cs high at least 3 cycles between them, two done pulses.
